// File: rtl/string_unpacker_if.sv
// Load and character stream bundle for string_unpacker.
// The slave modport is the unpacker; the master modport is the producer/consumer side.
interface string_unpacker_if #(
  parameter int MAX_CHARS = 16
);
  logic                     load_valid;
  logic                     load_ready;
  logic [8*MAX_CHARS-1:0]   load_data;
  logic                     char_valid;
  logic                     char_ready;
  logic [7:0]               char_data;
  logic                     char_last;
  logic                     done;
  logic                     busy;

  modport master (
    output load_valid, load_data, char_ready,
    input  load_ready, char_valid, char_data, char_last, done, busy
  );

  modport slave (
    input  load_valid, load_data, char_ready,
    output load_ready, char_valid, char_data, char_last, done, busy
  );
endinterface

// File: rtl/string_unpacker.sv
// Strips leading NUL padding from a packed string and streams its characters one byte per handshake.
// Optional macro STRING_UNPACKER_UPPER_EN folds 'a'..'z' to upper case on the char_data output.
module string_unpacker #(
  parameter int MAX_CHARS = 16
) (
  input  logic               c,
  input  logic               reset,
  string_unpacker_if.slave   bus
);

  localparam int W  = 8 * MAX_CHARS;
  localparam int CW = $clog2(MAX_CHARS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            char_valid_q, char_valid_d;
  logic [7:0]      char_data_q, char_data_d;
  logic            char_last_q, char_last_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [7:0]      top_byte_s;
  logic [W-1:0]    shifted_s;
  logic [7:0]      next_byte_s;
  logic            char_hs_s;

  function automatic logic [7:0] map_char(input logic [7:0] b);
`ifdef STRING_UNPACKER_UPPER_EN
    if (b >= 8'h61 && b <= 8'h7A) begin
      map_char = b - 8'h20;
    end else begin
      map_char = b;
    end
`else
    map_char = b;
`endif
  endfunction

  assign top_byte_s  = shift_q[W-1 -: 8];
  assign shifted_s   = shift_q << 8;
  assign next_byte_s = shifted_s[W-1 -: 8];
  assign char_hs_s   = char_valid_q & bus.char_ready;

  // State and datapath registers
  always_ff @(posedge c or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      rem_q        <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      char_last_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      rem_q        <= rem_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      char_last_q  <= char_last_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // Next state, shift register and remaining count
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          shift_d = bus.load_data;
          rem_d   = CW'(MAX_CHARS);
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (top_byte_s != 8'h00) begin
          state_d = SEND;
        end else if (rem_q > CW'(1)) begin
          shift_d = shifted_s;
          rem_d   = rem_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (char_hs_s && char_last_q) begin
          state_d = IDLE;
          rem_d   = rem_q - CW'(1);
        end else if (char_hs_s) begin
          shift_d = shifted_s;
          rem_d   = rem_q - CW'(1);
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered output values; the lookahead byte keeps SEND bubble-free
  always_comb begin
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    char_last_d  = char_last_q;
    done_d       = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        char_valid_d = 1'b0;
        char_last_d  = 1'b0;
      end
      SCAN: begin
        if (top_byte_s != 8'h00) begin
          char_valid_d = 1'b1;
          char_data_d  = map_char(top_byte_s);
          char_last_d  = (rem_q == CW'(1));
        end else if (rem_q <= CW'(1)) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      SEND: begin
        if (char_hs_s && char_last_q) begin
          char_valid_d = 1'b0;
          char_last_d  = 1'b0;
          done_d       = 1'b1;
        end else if (char_hs_s) begin
          char_valid_d = 1'b1;
          char_data_d  = map_char(next_byte_s);
          char_last_d  = (rem_q == CW'(2));
        end else begin
          char_valid_d = char_valid_q;
        end
      end
      default: begin
        char_valid_d = 1'b0;
        char_last_d  = 1'b0;
      end
    endcase
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.char_valid = char_valid_q;
  assign bus.char_data  = char_data_q;
  assign bus.char_last  = char_last_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_string_unpacker.sv
// Scoreboard bench for string_unpacker (MAX_CHARS=16): directed strings, backpressure, empty, reset abort, case fold.
module tb_string_unpacker;

  localparam int MC = 16;

  logic c;
  logic reset;
  int   cyc;

  string_unpacker_if #(.MAX_CHARS(MC)) bus ();

  string_unpacker #(.MAX_CHARS(MC)) dut (
    .c     (c),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [127:0] HELLO_IN = {40'h0, 88'h48656C6C6F20776F726C64};
  localparam logic [127:0] ALPHA_IN = 128'h4142434445464748494A4B4C4D4E4F50;
  localparam logic [127:0] OK_IN    = {112'h0, 16'h6F6B};
  localparam logic [127:0] T6_IN    = {104'h0, 24'h61007A};
  localparam logic [127:0] ALPHA_EXP = 128'h4142434445464748494A4B4C4D4E4F50;
`ifdef STRING_UNPACKER_UPPER_EN
  localparam logic [127:0] HELLO_EXP = 128'h48454C4C4F20574F524C44;
  localparam logic [127:0] OK_EXP    = 128'h4F4B;
  localparam logic [127:0] T6_EXP    = 128'h41005A;
  localparam logic [7:0]   O_CH      = 8'h4F;
  localparam logic [7:0]   L_CH      = 8'h4C;
`else
  localparam logic [127:0] HELLO_EXP = 128'h48656C6C6F20776F726C64;
  localparam logic [127:0] OK_EXP    = 128'h6F6B;
  localparam logic [127:0] T6_EXP    = 128'h61007A;
  localparam logic [7:0]   O_CH      = 8'h6F;
  localparam logic [7:0]   L_CH      = 8'h6C;
`endif

  logic [8:0] exp_q [$];
  int checks;
  int errors;
  int done_cnt;

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] e, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({e[8*i +: 8], (i == 0)});
  endtask

  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge c);
      if (bus.done) done_cnt++;
      if (bus.char_valid && bus.char_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char actual=%0h expected=none", bus.char_data);
        end else begin
          e = exp_q.pop_front();
          chk("char_data_last", 32'({bus.char_data, bus.char_last}), 32'(e));
        end
      end
    end
  endtask

  task automatic do_load(input logic [127:0] v, output int e0);
    bus.load_valid = 1'b1;
    bus.load_data  = v;
    @(posedge c); #1;
    e0 = cyc;
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (bus.char_valid) begin
        at = cyc;
        break;
      end
      @(posedge c); #1;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout actual=none expected=char_valid");
    end
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge c);
      if (bus.done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout actual=none expected=done");
    end
    @(posedge c); #1;
  endtask

  initial begin
    int e0, at, dn, d0;
    reset          = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.char_ready = 1'b1;
    cyc            = 0;
    checks         = 0;
    errors         = 0;
    done_cnt       = 0;
    fork
      monitor();
    join_none
    #1 reset = 1'b1;
    #3;
    chk("rst_char_valid", 32'(bus.char_valid), 32'd0);
    chk("rst_char_data",  32'(bus.char_data),  32'd0);
    chk("rst_char_last",  32'(bus.char_last),  32'd0);
    chk("rst_done",       32'(bus.done),       32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
    @(posedge c); #1;
    reset = 1'b0;
    @(posedge c); #1;

    // 1: padded string, free-running consumer
    push_exp(HELLO_EXP, 11);
    do_load(HELLO_IN, e0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_load_ready_scan", 32'(bus.load_ready), 32'd0);
    wait_valid(40, at);
    chk("t1_first_latency", 32'(at - e0), 32'd6);
    wait_done(40, dn);
    chk("t1_done_latency", 32'(dn - e0), 32'd17);
    chk("t1_load_ready", 32'(bus.load_ready), 32'd1);
    chk("t1_busy_after", 32'(bus.busy), 32'd0);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // 2: backpressure on the first 'o'
    push_exp(HELLO_EXP, 11);
    do_load(HELLO_IN, e0);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.char_valid && bus.char_data == O_CH) begin
        at = cyc;
        break;
      end
      @(posedge c); #1;
    end
    chk("t2_o_seen_at", 32'(at - e0), 32'd10);
    bus.char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge c);
      chk("t2_hold_data",  32'(bus.char_data),  32'(O_CH));
      chk("t2_hold_valid", 32'(bus.char_valid), 32'd1);
      chk("t2_hold_last",  32'(bus.char_last),  32'd0);
      @(posedge c); #1;
    end
    bus.char_ready = 1'b1;
    wait_done(40, dn);
    chk("t2_done_latency", 32'(dn - e0), 32'd20);
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: all-NUL vector
    d0 = done_cnt;
    do_load(128'h0, e0);
    wait_done(40, dn);
    chk("t3_done_latency", 32'(dn - e0), 32'd16);
    chk("t3_busy_after", 32'(bus.busy), 32'd0);
    chk("t3_done_count", 32'(done_cnt - d0), 32'd1);

    // 4: unpadded string with load_valid held during SEND
    push_exp(ALPHA_EXP, 16);
    bus.load_valid = 1'b1;
    bus.load_data  = ALPHA_IN;
    @(posedge c); #1;
    e0 = cyc;
    bus.load_data = {16{8'h5A}};
    wait_valid(40, at);
    chk("t4_first_latency", 32'(at - e0), 32'd1);
    chk("t4_load_ready_send", 32'(bus.load_ready), 32'd0);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge c);
      if (bus.done) begin
        at = cyc;
        bus.load_valid = 1'b0;
        break;
      end
    end
    bus.load_valid = 1'b0;
    chk("t4_done_latency", 32'(at - e0), 32'd17);
    repeat (3) @(posedge c);
    #1;
    chk("t4_no_reload", 32'(bus.busy), 32'd0);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    // 5: reset abort in SEND, then immediate reload
    push_exp(HELLO_EXP, 11);
    do_load(HELLO_IN, e0);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.char_valid && bus.char_data == L_CH) begin
        at = cyc;
        break;
      end
      @(posedge c); #1;
    end
    chk("t5_l_seen", 32'(at >= 0), 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.char_valid), 32'd0);
    chk("t5_rst_busy",  32'(bus.busy),       32'd0);
    exp_q.delete();
    @(posedge c); #1;
    reset = 1'b0;
    push_exp(OK_EXP, 2);
    do_load(OK_IN, e0);
    chk("t5_reload_busy", 32'(bus.busy), 32'd1);
    chk("t5_no_abort_done", 32'(done_cnt - d0), 32'd0);
    wait_valid(40, at);
    chk("t5_first_latency", 32'(at - e0), 32'd15);
    wait_done(40, dn);
    chk("t5_done_latency", 32'(dn - e0), 32'd17);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: lowercase / embedded NUL bytes
    push_exp(T6_EXP, 3);
    do_load(T6_IN, e0);
    wait_valid(40, at);
    chk("t6_first_latency", 32'(at - e0), 32'd14);
    wait_done(40, dn);
    chk("t6_done_latency", 32'(dn - e0), 32'd17);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge c);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/string_unpacker.md
Name: string_unpacker

Overview:
- Reader side of the packed string format. A string literal is stored in an 8*N-bit vector: first character in the top byte, unused leading bytes NUL (0x00).
- The block accepts one packed vector over a valid/ready load port and strips leading NUL padding.
- It emits the characters first-to-last, one byte per handshake, on a valid/ready stream.
- Sits between any string-producing block and a byte-serial consumer (display, console, serial TX).

Parameters:
MAX_CHARS, 16, capacity in characters; load_data width is 8*MAX_CHARS; legal range 1..64

Ports:
c  in  1  clock, all state updates on posedge c
reset  in  1  asynchronous, active-high reset
load_valid  in  1  load_data is valid
load_ready  out  1  block accepts a load (high only in IDLE)
load_data  in  8*MAX_CHARS  packed string, first char in bits [8*MAX_CHARS-1 -: 8]
char_valid  out  1  char_data is valid
char_ready  in  1  consumer accepts char_data
char_data  out  8  current character
char_last  out  1  current character is the final one
done  out  1  one-cycle pulse: string finished, or empty string
busy  out  1  state != IDLE

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, shift register=0, remaining count=0.
  - char_valid=0, char_data=0, char_last=0, done=0, busy=0, load_ready=1.
- All outputs except load_ready are registered. load_ready = (state==IDLE).
- IDLE:
  - On load handshake (load_valid & load_ready) at edge E0: latch load_data, remaining=MAX_CHARS, go to SCAN.
  - load_valid is ignored outside IDLE.
- SCAN, one byte per cycle:
  - Top byte == 0x00 and remaining>1: shift left 8, remaining-1, stay in SCAN.
  - Top byte == 0x00 and remaining==1: empty string. Go to IDLE and pulse done. No character is emitted.
  - Top byte != 0x00: go to SEND.
- SEND:
  - char_valid=1, char_data=top byte, char_last=(remaining==1).
  - On handshake with char_last=0: shift left 8, remaining-1, stay in SEND. The next char is valid the following cycle with no bubble.
  - On handshake with char_last=1: go to IDLE, char_valid=0, pulse done.
- Latency: with P leading NULs, char_valid first rises at edge E0+P+1. An empty string returns to IDLE with done at edge E0+MAX_CHARS.
- Throughput: 1 char/cycle when char_ready is held high.
- Backpressure: while char_valid & !char_ready, char_data and char_last hold stable. No drop, no duplicate.
- Embedded NULs: after the first non-NUL, every remaining byte is emitted, including 0x00.
- A string with no padding (top byte non-NUL) emits all MAX_CHARS characters.
- Reset mid-SCAN or mid-SEND aborts the string with no done pulse. A new load is accepted in the first cycle after reset deasserts.
- Remaining count width is clog2(MAX_CHARS+1). It never wraps: it is decremented only while >1, or on the final handshake.

Optional Feature:
- Macro: STRING_UNPACKER_UPPER_EN.
- Defined: char_data maps 0x61..0x7A ('a'..'z') to 0x41..0x5A. All other bytes, including NUL and 0x80..0xFF, pass unchanged. The mapping is applied on the registered output path and adds no latency. The NUL-skip decision is made on the raw byte.
- Undefined: char_data is the raw byte. The conversion logic is absent.

Test Plan:
1. MAX_CHARS=16, load "Hello world" (5 leading NULs), char_ready=1 -> char_valid first at E0+6. Output is 48 65 6C 6C 6F 20 77 6F 72 6C 64 on consecutive cycles, char_last only on 0x64, done pulse one cycle later, load_ready=1.
2. Same load, char_ready=0 for 3 cycles while char_data=0x6F -> 0x6F held for 4 cycles, then 20 77 ... continue. Total 11 chars, none dropped or duplicated.
3. Load all-zero vector -> char_valid never asserts, done pulses at E0+16, busy=0 afterwards.
4. Load "ABCDEFGHIJKLMNOP" (no padding) -> first char 0x41 at E0+1, 16 chars, char_last on 0x50. load_valid held high during SEND is ignored until IDLE.
5. Assert reset while char_data=0x6C in SEND -> char_valid=0 and busy=0 immediately, no done. After release, load "ok" -> emits 6F 6B.
6. With STRING_UNPACKER_UPPER_EN, load bytes 61 00 7A at the bottom of the vector -> emits 41 00 5A. Without the macro -> emits 61 00 7A.
